// File: rtl/rand_server.sv
// rand_server: shared 12-bit LFSR draw service, req/ack handshake, mask-and-reject bounded sampling.
// Define RAND_SERVER_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module rand_server #(
    parameter int          NREQ    = 4,
    parameter logic [11:0] SEED    = 12'h001,
    parameter int          MAX_TRY = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [12*NREQ-1:0] lim,
    output logic [NREQ-1:0]    ack,
    output logic [11:0]        rnd,
    output logic               busy
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, DRAW, RESP} state_t;
    state_t          state_q;
    logic [11:0]     lfsr_q, lfsr_d, lfsr_t;
    logic [IW-1:0]   idx_q, win;
    logic [12:0]     lim_q, lim_d;
    logic [11:0]     mask_q, mask_d, lim_m1, lim_sel, cand, res_q, rnd_q;
    logic [3:0]      tries_q;
    logic [NREQ-1:0] ack_q;
    logic            hit, last;
`ifdef RAND_SERVER_RR_EN
    logic [IW-1:0]   ptr_q;
`endif
    always_comb begin
        lfsr_t = {lfsr_q[6] ^ lfsr_q[4] ^ lfsr_q[1] ^ lfsr_q[0], lfsr_q[11:1]};
        lfsr_d = (lfsr_q == 12'h000) ? 12'hfff : (lfsr_t == 12'hfff) ? 12'h000 : lfsr_t;
    end
`ifdef RAND_SERVER_RR_EN
    // first set request at or after the pointer, wrapping
    always_comb begin
        int c;
        logic found;
        c = 0;
        found = 1'b0;
        win = '0;
        for (int j = 0; j < NREQ; j++) begin
            c = (int'(ptr_q) + j) % NREQ;
            if (!found && req[c]) begin
                found = 1'b1;
                win = IW'(c);
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int j = NREQ - 1; j >= 0; j--)
            if (req[j]) win = IW'(j);
    end
`endif
    // bound 0 stands for 4096; mask is L-1 with every bit below its MSB filled
    always_comb begin
        lim_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (win == IW'(i)) lim_sel = lim[12*i +: 12];
        lim_d = (lim_sel == 12'h000) ? 13'h1000 : {1'b0, lim_sel};
        lim_m1 = 12'(lim_d - 13'd1);
        mask_d = lim_m1 | (lim_m1 >> 1);
        mask_d = mask_d | (mask_d >> 2);
        mask_d = mask_d | (mask_d >> 4);
        mask_d = mask_d | (mask_d >> 8);
    end
    assign cand = lfsr_q & mask_q;
    assign hit  = {1'b0, cand} < lim_q;
    assign last = tries_q == 4'(MAX_TRY - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            idx_q   <= '0;
            lim_q   <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            res_q   <= '0;
            rnd_q   <= '0;
            ack_q   <= '0;
`ifdef RAND_SERVER_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            lfsr_q <= lfsr_d;
            ack_q  <= '0;
            case (state_q)
                IDLE: if (|req) begin
                    idx_q   <= win;
                    lim_q   <= lim_d;
                    mask_q  <= mask_d;
                    tries_q <= '0;
                    state_q <= DRAW;
                end
                DRAW: if (hit || last) begin
                    res_q   <= hit ? cand : cand - lim_q[11:0];
                    state_q <= RESP;
                end else begin
                    tries_q <= tries_q + 4'd1;
                end
                RESP: begin
                    ack_q   <= NREQ'(1) << idx_q;
                    rnd_q   <= res_q;
`ifdef RAND_SERVER_RR_EN
                    ptr_q   <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack  = ack_q;
    assign rnd  = rnd_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_rand_server.sv
// tb_rand_server: directed checks of rand_server against an LFSR step model and hand-derived values.
// Two instances share clock and reset: MAX_TRY=8 and MAX_TRY=1.
module tb_rand_server;
    localparam int N = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req0 = '0, req1 = '0, ack0, ack1;
    logic [12*N-1:0] lim0 = '0, lim1 = '0;
    logic [11:0] rnd0, rnd1, m;
    logic busy0, busy1;
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    rand_server #(.NREQ(N), .SEED(12'h001), .MAX_TRY(8)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .lim(lim0), .ack(ack0), .rnd(rnd0), .busy(busy0));
    rand_server #(.NREQ(N), .SEED(12'h001), .MAX_TRY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .lim(lim1), .ack(ack1), .rnd(rnd1), .busy(busy1));
    function automatic logic [11:0] step(input logic [11:0] s);
        logic [11:0] t;
        t = {s[6] ^ s[4] ^ s[1] ^ s[0], s[11:1]};
        if (s == 12'h000) return 12'hfff;
        return (t == 12'hfff) ? 12'h000 : t;
    endfunction
    always @(posedge clk) m <= !rst_n ? 12'h001 : step(m);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // called 1 time unit after the grant edge; m then holds the value the first attempt sees
    task automatic draw(input bit d, input int who, input int l, input int mt, input string tag,
                        output logic [11:0] er);
        int L, t, n;
        logic [11:0] mask, s, cand;
        L = (l == 0) ? 4096 : l;
        mask = '0;
        while (int'(mask) < L - 1) mask = {mask[10:0], 1'b1};
        s = m;
        cand = '0;
        for (t = 0; t < mt; t++) begin
            cand = s & mask;
            if (int'(cand) < L || t == mt - 1) break;
            s = step(s);
        end
        er = (int'(cand) < L) ? cand : 12'(int'(cand) - L);
        chk({tag, " busy"}, d ? busy1 : busy0, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((d ? ack1 : ack0) == '0 && n < 20);
        chk({tag, " latency"}, n, t + 2);
        chk({tag, " ack"}, d ? ack1 : ack0, 1 << who);
        chk({tag, " rnd"}, d ? rnd1 : rnd0, er);
        chk({tag, " in range"}, int'(d ? rnd1 : rnd0) < L, 1);
    endtask
    task automatic post(input bit d, input string tag, input logic [11:0] er);
        @(posedge clk); #1;
        chk({tag, " ack pulse"}, d ? ack1 : ack0, 0);
        chk({tag, " rnd hold"}, d ? rnd1 : rnd0, er);
    endtask
    task automatic single(input bit d, input int who, input int l, input int mt, input string tag);
        logic [11:0] er;
        @(negedge clk);
        if (d) begin req1[who] = 1'b1; lim1[12*who +: 12] = 12'(l); end
        else begin req0[who] = 1'b1; lim0[12*who +: 12] = 12'(l); end
        @(posedge clk); #1;
        req0 = '0;
        req1 = '0;
        draw(d, who, l, mt, tag, er);
        post(d, tag, er);
    endtask
    initial begin
        logic [11:0] er;
        logic seen;
        int w;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset ack", ack0, 0);
        chk("reset rnd", rnd0, 0);
        chk("reset busy", busy0, 0);
        chk("reset ack1", ack1, 0);
        repeat (3) single(0, 0, 0, 8, "full12");
        repeat (20) single(0, 1, 1, 8, "lim1");
        repeat (10) single(0, 2, 2049, 8, "retry2049");
        repeat (5) single(0, 3, 5, 8, "retry5");
        repeat (10) single(1, 2, 2049, 1, "fb2049");
        repeat (6) single(1, 0, 3, 1, "fb3");
        // fresh reset so the round-robin pointer starts at 0
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req0 = '1;
        lim0 = {N{12'd16}};
        @(posedge clk); #1;
        for (int g = 0; g < 5; g++) begin
`ifdef RAND_SERVER_RR_EN
            w = g % N;
`else
            w = 0;
`endif
            draw(0, w, 16, 8, "arb", er);
            if (g == 4) req0 = '0;
            post(0, "arb", er);
        end
        @(negedge clk);
        req0[2] = 1'b1;
        lim0 = '0;
        @(posedge clk); #1;
        req0 = '0;
        chk("middraw busy", busy0, 1);
        @(negedge clk); rst_n = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen |= (ack0 != '0);
        end
        chk("middraw busy after rst", busy0, 0);
        chk("middraw rnd after rst", rnd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req0[1] = 1'b1;
        @(posedge clk); #1;
        req0 = '0;
        seen |= (ack0 != '0);
        chk("middraw no ack", seen, 0);
        // first edge after release steps SEED 001 -> 800, full-range draw returns it
        draw(0, 1, 0, 8, "after rst", er);
        chk("after rst seed value", rnd0, 12'h800);
        post(0, "after rst", 12'h800);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rand_server.md
# rand_server

Shared random-number service for the game logic. Owns one free-running 12-bit LFSR (the team's standard generator step) and grants draws to NREQ requesters through a req/ack handshake with round-robin arbitration. Each requester supplies its own upper bound; the block returns a value uniformly in [0, limit) using mask-and-reject sampling with a bounded retry count. It sits between the game FSMs (target placement, timing jitter) and replaces per-consumer generator instances.

## Interface
- NREQ, 4: number of requesters (2..8).
- SEED, 12'h001: LFSR value loaded at reset.
- MAX_TRY, 8: draw attempts before the fallback reduction (1..15).

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NREQ  request per requester; level, held until ack.
- lim  in  12*NREQ  per-requester bound, slice i = lim[12*i+11:12*i]; 0 means 4096.
- ack  out  NREQ  one-hot, one-cycle pulse; rnd valid in the same cycle.
- rnd  out  12  result for the acked requester; holds until the next ack.
- busy  out  1  high in DRAW and RESP.

## Operation
- LFSR step, every clock, never stalled: if s==0 then s'=12'hfff; else b=s[6]^s[4]^s[1]^s[0], t={b,s[11:1]}, s'=(t==12'hfff)?0:t.
- FSM states IDLE, DRAW, RESP.
- IDLE: if any req bit set, pick winner, latch idx, L=lim slice (0→4096), mask = smallest 2^k−1 ≥ L−1 (L=1 → mask 0), tries=0; → DRAW. Else stay.
- DRAW (one attempt per cycle): cand = s & mask, where s is the current LFSR register. If cand<L, or tries==MAX_TRY−1, register rnd = (cand<L) ? cand : cand−L; → RESP. Else tries++ and stay.
- Fallback is always in range because mask < 2L.
- RESP: ack[idx]=1 for exactly this cycle; → IDLE.
- Arbitration: round-robin. The pointer is set to idx+1 (mod NREQ) at RESP. The winner is the first set req at or after the pointer.
- req is latched at grant. Deasserting it before ack does not cancel: the draw completes and ack is still pulsed. req still high in the IDLE cycle after RESP is a new request.
- lim is sampled only at grant; later changes do not affect the draw in progress.

## Timing
- Reset values: state IDLE, LFSR=SEED, ack=0, rnd=0, busy=0, rr pointer=0, tries=0.
- Latency, req sampled high in IDLE at edge k:
  - DRAW during cycle k..k+1.
  - First-try success: ack and rnd visible after edge k+2.
  - Each rejection adds 1 cycle; maximum ack after edge k+1+MAX_TRY.
- Throughput: one grant per 3 cycles minimum (IDLE, DRAW, RESP).
- Simultaneous req: exactly one is served per grant; the others wait. No requester waits more than NREQ−1 grants.
- Reset asserted mid-draw: the draw is discarded, no ack is pulsed, and all state returns to reset values on that edge.
- LFSR zero-lock: states 000 and fff are escaped as in the step rule. SEED=0 is legal.

## Configuration
- RAND_SERVER_RR_EN defined: round-robin arbitration as described.
- RAND_SERVER_RR_EN undefined: fixed priority, lowest index wins. The pointer register is removed and starvation is permitted.

## Test plan
- Reset with SEED=12'h001 and no req for 5 cycles → ack=0, rnd=0, busy=0. The LFSR sequence matches the bench step model (001→800→400…).
- req[0] with lim=0 at edge k → ack[0] after edge k+2. rnd equals the model LFSR value sampled in DRAW, full 12 bits.
- req[1] with lim=1 → rnd=0 on the first try, ack after 2 cycles, for 20 consecutive requests.
- req=4'b1111 held, all lim=16 → acks in order 0,1,2,3,0, each rnd<16. With RAND_SERVER_RR_EN undefined, ack[0] every grant.
- lim=2049 (mask fff), MAX_TRY=1 → with cand≥2049 the output is rnd=cand−2049; every rnd is <2049; bench model matches cycle-exactly.
- rst_n low during DRAW → no ack pulse. After release, LFSR=SEED and a new req is served with 2-cycle latency.
